// File: rtl/latency_result_collector.sv
// Captures fixed-latency pipeline results into a FWFT FIFO, with credit-based issue throttling
// so that a result can never arrive when there is no room to store it.
module latency_result_collector #(
    parameter int unsigned LATENCY_CYCLES = 23,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned VEC_LEN        = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [DATA_WIDTH-1:0]   pipe_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic [$clog2(DEPTH):0]  inflight
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
    localparam logic [7:0]    LastIdx  = 8'(VEC_LEN - 1);

    logic                      accept;
    logic                      pop;
    logic                      tap;
    logic [LATENCY_CYCLES-1:0] vld_q, vld_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic [CW-1:0]             inflight_q, inflight_d;
    logic [7:0]                idx_q, idx_d;
    logic [DATA_WIDTH-1:0]     mem_q [DEPTH];

    always_comb begin
        issue_ready = (inflight_q < DepthCnt);
        out_valid   = (count_q != '0);
        out_data    = mem_q[rd_ptr_q];
        out_last    = out_valid & (idx_q == LastIdx);
        inflight    = inflight_q;

        accept = issue_valid & issue_ready;
        pop    = out_valid & out_ready;
        tap    = vld_q[LATENCY_CYCLES-1];

        // Shift toward the tap; a one-stage line degenerates to a single flop of accept.
        vld_d    = vld_q << 1;
        vld_d[0] = accept;

        wr_ptr_d = tap ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        unique case ({tap, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        unique case ({accept, pop})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase

        idx_d = idx_q;
        if (pop) begin
            idx_d = (idx_q == LastIdx) ? 8'd0 : idx_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            idx_q      <= '0;
        end else begin
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            idx_q      <= idx_d;
        end
    end

    // Storage is not reset; credits guarantee a tap write never lands on an unread entry.
    always_ff @(posedge clk) begin
        if (tap) begin
            mem_q[wr_ptr_q] <= pipe_data;
        end
    end

endmodule

// File: tb/tb_latency_result_collector.sv
// Randomized bench for latency_result_collector: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, and a one-cycle-latency instance.
module tb_latency_result_collector;

    localparam int L     = 23;
    localparam int DEPTH = 32;
    localparam int VLEN  = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [31:0] pipe_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic [5:0]  inflight;

    logic        d1_issue_valid = 1'b0;
    logic        d1_issue_ready;
    logic [31:0] d1_pipe_data = '0;
    logic        d1_out_valid;
    logic        d1_out_ready = 1'b1;
    logic [31:0] d1_out_data;
    logic        d1_out_last;
    logic [5:0]  d1_inflight;

    always #5 clk = ~clk;

    latency_result_collector #(
        .LATENCY_CYCLES(L), .DATA_WIDTH(32), .DEPTH(DEPTH), .VEC_LEN(VLEN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .pipe_data(pipe_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .inflight(inflight)
    );

    latency_result_collector #(
        .LATENCY_CYCLES(1), .DATA_WIDTH(32), .DEPTH(DEPTH), .VEC_LEN(VLEN)
    ) dut_l1 (
        .clk(clk), .reset_n(reset_n), .issue_valid(d1_issue_valid),
        .issue_ready(d1_issue_ready), .pipe_data(d1_pipe_data), .out_valid(d1_out_valid),
        .out_ready(d1_out_ready), .out_data(d1_out_data), .out_last(d1_out_last),
        .inflight(d1_inflight)
    );

    // Reference model: results waiting in the pipe (due cycle), results buffered, credits.
    int          cyc = 0;
    int          due_q[$];
    logic [31:0] fifo_q[$];
    int          m_inflight = 0;
    int          m_idx = 0;
    int          n_acc = 0;
    logic        popped;
    logic        popped_last;
    int          total = 0;
    int          bad = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_reset();
        due_q.delete();
        fifo_q.delete();
        m_inflight = 0;
        m_idx = 0;
    endfunction

    always @(negedge clk) begin
        check("issue_ready", {31'd0, issue_ready}, {31'd0, m_inflight < DEPTH});
        check("inflight", {26'd0, inflight}, m_inflight);
        check("out_valid", {31'd0, out_valid}, {31'd0, fifo_q.size() != 0});
        check("out_last", {31'd0, out_last},
              {31'd0, (fifo_q.size() != 0) && (m_idx == VLEN - 1)});
        if (fifo_q.size() != 0) check("out_data", out_data, fifo_q[0]);
    end

    task automatic tick(input logic iv, input logic ordy, input logic [31:0] pd);
        logic acc;
        logic pp;
        issue_valid  = iv;
        out_ready    = ordy;
        pipe_data    = pd;
        d1_pipe_data = 32'h1000 + 32'(cyc);
        acc = reset_n && iv && (m_inflight < DEPTH);
        pp  = reset_n && ordy && (fifo_q.size() != 0);
        popped      = pp;
        popped_last = out_last;
        @(posedge clk);
        if (reset_n) begin
            if (pp) begin
                void'(fifo_q.pop_front());
                m_idx = (m_idx == VLEN - 1) ? 0 : m_idx + 1;
            end
            if (due_q.size() != 0 && due_q[0] == cyc) begin
                fifo_q.push_back(pd);
                void'(due_q.pop_front());
            end
            if (acc) begin
                due_q.push_back(cyc + L);
                n_acc++;
            end
            m_inflight = m_inflight + int'(acc) - int'(pp);
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        tick(1'b0, 1'b0, $urandom);
        tick(1'b0, 1'b0, $urandom);
        reset_n = 1'b1;
    endtask

    initial begin
        int s;
        int pv;
        int pr;
        logic [31:0] mask;

        do_reset();

        // One-cycle latency instance: 10 back-to-back issues, drained every cycle.
        s = cyc;
        for (int k = 0; k < 14; k++) begin
            d1_issue_valid = (k < 10);
            tick(1'b0, 1'b0, $urandom);
            check("l1_valid", {31'd0, d1_out_valid}, {31'd0, (k >= 1) && (k <= 10)});
            if (k >= 1 && k <= 10) check("l1_data", d1_out_data, 32'h1000 + 32'(s + k));
            check("l1_inflight", {26'd0, d1_inflight},
                  ((k + 1 < 10) ? k + 1 : 10) - ((k - 1 < 0) ? 0 : ((k - 1 > 10) ? 10 : k - 1)));
        end
        d1_issue_valid = 1'b0;

        // Single op: accept at cycle 5 after reset, result presented 23 cycles later.
        do_reset();
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, $urandom);
        tick(1'b1, 1'b0, $urandom);
        check("so_inflight", {26'd0, inflight}, 32'd1);
        for (int k = 0; k < L - 1; k++) tick(1'b0, 1'b0, $urandom);
        check("so_early", {31'd0, out_valid}, 32'd0);
        tick(1'b0, 1'b0, 32'hA5A5_0001);
        check("so_valid", {31'd0, out_valid}, 32'd1);
        check("so_data", out_data, 32'hA5A5_0001);
        tick(1'b0, 1'b1, $urandom);
        check("so_popped", {26'd0, inflight}, 32'd0);

        // Backpressure fill, then full-boundary issue/pop interplay, then drain.
        n_acc = 0;
        for (int k = 0; k < 40; k++) tick(1'b1, 1'b0, $urandom);
        check("fill_accepts", n_acc, 32'd32);
        check("fill_ready", {31'd0, issue_ready}, 32'd0);
        for (int k = 0; k < L + 2; k++) tick(1'b1, 1'b0, $urandom);
        check("fill_inflight", {26'd0, inflight}, 32'd32);
        check("fill_model", fifo_q.size(), 32'd32);
        tick(1'b0, 1'b1, $urandom);
        check("full_pop", {26'd0, inflight}, 32'd31);
        tick(1'b1, 1'b1, $urandom);
        check("full_both", {26'd0, inflight}, 32'd31);
        tick(1'b1, 1'b0, $urandom);
        check("full_again", {26'd0, inflight}, 32'd32);
        check("full_ready", {31'd0, issue_ready}, 32'd0);
        for (int k = 0; k < 80; k++) tick(1'b0, 1'b1, $urandom);
        check("drained", {26'd0, inflight}, 32'd0);

        // Vector framing over 25 results.
        do_reset();
        for (int k = 0; k < 25; k++) tick(1'b1, 1'b0, $urandom);
        for (int k = 0; k < L + 2; k++) tick(1'b0, 1'b0, $urandom);
        mask = '0;
        for (int k = 0; k < 25; k++) begin
            tick(1'b0, 1'b1, $urandom);
            if (popped && popped_last) mask[k] = 1'b1;
        end
        check("vec_last_mask", mask, 32'h0008_0200);
        check("vec_idx_model", m_idx, 32'd5);

        // Reset with 7 ops in the pipe and 3 buffered; stale results must not land.
        for (int k = 0; k < 10; k++) tick(1'b1, 1'b0, $urandom);
        for (int k = 0; k < 16; k++) tick(1'b0, 1'b0, $urandom);
        check("prereset_model", fifo_q.size(), 32'd3);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_inflight", {26'd0, inflight}, 32'd0);
        check("rst_ready", {31'd0, issue_ready}, 32'd1);
        tick(1'b0, 1'b0, $urandom);
        reset_n = 1'b1;
        for (int k = 0; k < 30; k++) tick(1'b0, 1'b0, $urandom);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);

        // Randomized traffic with varying issue and drain densities.
        for (int ph = 0; ph < 6; ph++) begin
            pv = $urandom_range(10, 100);
            pr = $urandom_range(0, 100);
            for (int k = 0; k < 250; k++) begin
                tick(($urandom_range(0, 99) < pv), ($urandom_range(0, 99) < pr), $urandom);
            end
        end
        for (int k = 0; k < 100; k++) tick(1'b0, 1'b1, $urandom);
        check("final_inflight", {26'd0, inflight}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/latency_result_collector.md
# latency_result_collector

Consumer-side companion to the fixed-latency pipeline counter. It tracks every operation issued into a fixed-latency pipelined arithmetic unit (exp, divide, accumulate stages of the softmax datapath). It captures the unit's output exactly LATENCY_CYCLES after each accepted issue and buffers results in a FIFO. Results are presented downstream on a ready/valid interface with a per-vector last flag. Credit-based issue throttling guarantees no result is ever dropped when downstream stalls.

## Interface
- LATENCY_CYCLES, 23, pipeline latency in cycles (1..63).
- DATA_WIDTH, 32, result width.
- DEPTH, 32, FIFO entries; power of two, at least 2.
- VEC_LEN, 10, elements per softmax vector, used for out_last (1..255).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  upstream requests to issue one op into the pipeline this cycle.
- issue_ready  out  1  credit available; an op is accepted when issue_valid & issue_ready.
- pipe_data  in  DATA_WIDTH  pipeline output; valid only in the cycle the internal tap fires.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  DATA_WIDTH  FIFO head data.
- out_last  out  1  head is element VEC_LEN-1 of the current vector.
- inflight  out  $clog2(DEPTH)+1  ops accepted but not yet popped (in pipeline plus in FIFO).

## Operation
- accept = issue_valid & issue_ready. issue_valid without issue_ready is ignored and needs no hold.
- Valid delay line: LATENCY_CYCLES flops shift accept. The tap (last stage) fires in cycle t+LATENCY_CYCLES for an op accepted in cycle t.
- On a tap cycle, pipe_data is written into the FIFO at the write pointer at that clock edge. Write is unconditional; the credit scheme guarantees space.
- pop = out_valid & out_ready. It advances the read pointer.
- Credit counter inflight:
  - +1 on accept, -1 on pop, unchanged when both occur.
  - Range 0..DEPTH.
  - issue_ready = (inflight < DEPTH), decoded from the registered counter.
- FIFO is first-word-fall-through. out_data is the head entry. out_valid = (fifo count != 0).
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty come from a separate count register or an extra pointer bit.
- Element index idx, 8 bits: increments on pop, wraps to 0 after VEC_LEN-1. out_last = out_valid & (idx == VEC_LEN-1).
- Simultaneous write and pop in the same cycle: count unchanged and both pointers advance. This is legal when the FIFO is full, and when the FIFO holds one entry.
- Reset (async assert, any time, including mid-burst):
  - Delay line cleared; in-flight ops are discarded.
  - FIFO pointers and count = 0. idx = 0. inflight = 0.
  - Outputs at reset: issue_ready = 1, out_valid = 0, out_last = 0, out_data = don't-care (entries are not reset), inflight = 0.
  - Pipeline results arriving after reset are ignored, because the delay line was cleared.

## Timing
- Issue-to-result latency: accept in cycle t, capture at the end of cycle t+L, out_valid high in cycle t+L+1. Minimum total latency is LATENCY_CYCLES+1.
- Throughput: one issue and one pop per cycle sustained when out_ready stays high, with no bubbles.
- issue_ready falls in the cycle after the accept that makes inflight = DEPTH. It rises in the cycle after the pop that drops inflight below DEPTH.
- out_last and out_data are stable while out_valid & !out_ready.
- LATENCY_CYCLES = 1 is supported: the delay line is a single flop.

## Test plan
- Single op: reset, one accept at cycle 5 with pipe_data = 0xA5A5_0001 driven at cycle 28. Required: out_valid at cycle 29 with out_data = 0xA5A5_0001, and inflight steps 0→1→0 after pop.
- Backpressure fill: out_ready = 0, issue_valid held high for 40 cycles. Required:
  - Exactly 32 accepts, then issue_ready = 0.
  - All 32 distinct pipe_data values captured in order; inflight = 32.
  - Draining returns them in order with no loss.
- Full with simultaneous activity: at inflight = 32, release one pop. Then issue and pop in the same cycle. Required: inflight alternates 31/32 correctly and data order is preserved.
- Vector framing, VEC_LEN = 10: pop 25 results. Required: out_last on results 10 and 20 only; idx = 5 at the end.
- Reset mid-operation: assert reset_n low with 7 ops in the delay line and 3 in the FIFO, then release. Required:
  - out_valid = 0, inflight = 0, issue_ready = 1.
  - No spurious writes occur when the stale pipe outputs arrive.
- LATENCY_CYCLES = 1 regression: back-to-back issues for 10 cycles. Required: outputs start in cycle t+2 and stream at one per cycle.
